// File: rtl/sandbox_link_pkg.sv
// Shared state encodings and frame layout constants for the sandbox host link.
package sandbox_link_pkg;
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_COLLECT,
        RX_HOLD,
        RX_RELEASE
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_WAITHI,
        TX_WAITLO
    } tx_state_t;

    localparam int FRAME_BYTES  = 5;
    localparam int CTRL_IDX     = 0;
    localparam int DATA_MSB_IDX = 1;
endpackage

// File: rtl/sandbox_link_tx_serializer.sv
// Serializes {status, outputData} into five UART bytes on a rising edge of transmit_data.
module sandbox_link_tx_serializer
    import sandbox_link_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        transmit_data,
    input  logic [7:0]  status,
    input  logic [31:0] output_data,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_byte
);
    tx_state_t   tx_state_q, tx_state_d;
    logic [39:0] shift_q, shift_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        td_prev_q, td_prev_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            td_prev_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            td_prev_q  <= td_prev_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        td_prev_d  = transmit_data;
        tx_start   = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (transmit_data && !td_prev_q) begin
                    shift_d    = {status, output_data};
                    cnt_d      = '0;
                    tx_state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                if (!tx_busy) begin
                    tx_start   = 1'b1;
                    tx_state_d = TX_WAITHI;
                end
            end
            TX_WAITHI: begin
                if (tx_busy) tx_state_d = TX_WAITLO;
            end
            TX_WAITLO: begin
                // Byte is on the wire until busy drops, so only advance then.
                if (!tx_busy) begin
                    shift_d    = shift_q << 8;
                    cnt_d      = cnt_q + 3'd1;
                    tx_state_d = (cnt_q == 3'(FRAME_BYTES - 1)) ? TX_IDLE : TX_SEND;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign tx_byte = shift_q[39:32];
endmodule

// File: rtl/sandbox_host_link.sv
// Host framing link: assembles 5-byte command frames from the UART and sends 5-byte responses.
module sandbox_host_link
    import sandbox_link_pkg::*;
#(
    parameter int FRAME_TIMEOUT = 100000
) (
    input  logic        masterClock,
    input  logic        reset,
    input  logic        rxValid,
    input  logic [7:0]  rxByte,
    input  logic        txBusy,
    output logic        txStart,
    output logic [7:0]  txByte,
    output logic        dataReceived,
    output logic [7:0]  control,
    output logic [31:0] inputData,
    input  logic        clearDR,
    input  logic        transmitData,
    input  logic [7:0]  status,
    input  logic [31:0] outputData,
    output logic        frameError
);
    localparam int TW = (FRAME_TIMEOUT > 2) ? $clog2(FRAME_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(FRAME_TIMEOUT - 1);

    rx_state_t    rx_state_q, rx_state_d;
    logic [2:0]   idx_q, idx_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]   control_q, control_d;
    logic [31:0]  input_data_q, input_data_d;
    logic         frame_error_q, frame_error_d;

    always_ff @(posedge masterClock) begin
        if (reset) begin
            rx_state_q    <= RX_IDLE;
            idx_q         <= '0;
            to_cnt_q      <= '0;
            control_q     <= '0;
            input_data_q  <= '0;
            frame_error_q <= 1'b0;
        end else begin
            rx_state_q    <= rx_state_d;
            idx_q         <= idx_d;
            to_cnt_q      <= to_cnt_d;
            control_q     <= control_d;
            input_data_q  <= input_data_d;
            frame_error_q <= frame_error_d;
        end
    end

    always_comb begin
        rx_state_d    = rx_state_q;
        idx_d         = idx_q;
        to_cnt_d      = '0;
        control_d     = control_q;
        input_data_d  = input_data_q;
        frame_error_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rxValid) begin
                    control_d  = rxByte;
                    idx_d      = 3'(DATA_MSB_IDX);
                    rx_state_d = RX_COLLECT;
                end
            end
            RX_COLLECT: begin
                // A byte arriving on the expiry cycle wins over the timeout.
                if (rxValid) begin
                    case (idx_q)
                        3'd1:    input_data_d[31:24] = rxByte;
                        3'd2:    input_data_d[23:16] = rxByte;
                        3'd3:    input_data_d[15:8]  = rxByte;
                        default: input_data_d[7:0]   = rxByte;
                    endcase
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'(FRAME_BYTES - 1)) rx_state_d = RX_HOLD;
                end else if (to_cnt_q == TO_LAST) begin
                    frame_error_d = 1'b1;
                    idx_d         = 3'(CTRL_IDX);
                    rx_state_d    = RX_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            RX_HOLD: begin
                frame_error_d = rxValid;
                if (clearDR) rx_state_d = RX_RELEASE;
            end
            RX_RELEASE: begin
                frame_error_d = rxValid;
                if (!clearDR) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign dataReceived = (rx_state_q == RX_HOLD);
    assign control      = control_q;
    assign inputData    = input_data_q;
    assign frameError   = frame_error_q;

    sandbox_link_tx_serializer u_tx (
        .clk           (masterClock),
        .reset         (reset),
        .transmit_data (transmitData),
        .status        (status),
        .output_data   (outputData),
        .tx_busy       (txBusy),
        .tx_start      (txStart),
        .tx_byte       (txByte)
    );
endmodule

// File: doc/sandbox_host_link.md
# sandbox_host_link

Host-side framing link that sits between the UART byte receiver/transmitter pair and a sandbox process. It assembles 5-byte command frames from the UART into the `dataReceived`/`control`/`inputData` words the process consumes, and holds them until the process releases them via `clearDR`. When the process raises `transmitData`, the link serializes `status` and `outputData` back to the host as a 5-byte response frame.

## Interface
- `FRAME_TIMEOUT`, default 100000: cycles allowed between consecutive bytes of one command frame before the partial frame is discarded.
- `masterClock`  in  1: operating clock.
- `reset`  in  1: synchronous, active-high reset.
- `rxValid`  in  1: one-cycle strobe from the UART receiver; `rxByte` is valid.
- `rxByte`  in  8: received byte.
- `txBusy`  in  1: UART transmitter busy; rises the cycle after `txStart` and stays high until the byte is sent.
- `txStart`  out  1: one-cycle strobe that launches `txByte`.
- `txByte`  out  8: byte to send; stable from `txStart` until `txBusy` falls.
- `dataReceived`  out  1: a complete command frame is held for the process.
- `control`  out  8: frame byte 0.
- `inputData`  out  32: frame bytes 1..4, big-endian (byte 1 = [31:24]).
- `clearDR`  in  1: process releases the held frame.
- `transmitData`  in  1: process requests a response; the link acts on the rising edge only.
- `status`  in  8: response byte 0.
- `outputData`  in  32: response bytes 1..4, big-endian.
- `frameError`  out  1: one-cycle pulse on inter-byte timeout or on a byte dropped while a frame is held.

## Operation
- RX FSM states:
  - RX_IDLE: the first `rxValid` stores `control`, sets `idx`=1 and goes to RX_COLLECT.
  - RX_COLLECT: each `rxValid` stores byte `idx` into `inputData` and increments `idx`. Storing `idx`=4 goes to RX_HOLD.
  - RX_HOLD: `dataReceived`=1. When `clearDR`=1, go to RX_RELEASE.
  - RX_RELEASE: `dataReceived`=0. When `clearDR`=0, go to RX_IDLE.
- Timeout counter:
  - Runs only in RX_COLLECT and restarts on every `rxValid`.
  - Reaching `FRAME_TIMEOUT`-1 discards the partial frame, pulses `frameError` and returns to RX_IDLE.
  - `control`/`inputData` keep their last values.
- Bytes arriving in RX_HOLD or RX_RELEASE are dropped and each one pulses `frameError`.
- TX FSM states:
  - TX_IDLE: a rising edge on `transmitData` (current 1, previous 0) captures {`status`,`outputData`} into a 40-bit shift register, sets `cnt`=0 and goes to TX_SEND.
  - TX_SEND: when `txBusy`=0, pulse `txStart` with `txByte`=shift[39:32] and go to TX_WAITHI.
  - TX_WAITHI: wait for `txBusy`=1, then go to TX_WAITLO.
  - TX_WAITLO: wait for `txBusy`=0. Then shift left 8 and increment `cnt`. At `cnt`=4, go to TX_IDLE; otherwise go to TX_SEND.
- Response byte order: `status`, then `outputData` MSB first.
- `transmitData` edges during TX_SEND, TX_WAITHI or TX_WAITLO are ignored. A new response requires `transmitData` to fall and rise again after TX_IDLE is reached.
- RX and TX run independently. A frame may be held while a response is being sent.

## Timing
- Reset values:
  - `txStart`=0, `txByte`=0, `dataReceived`=0, `control`=0, `inputData`=0, `frameError`=0.
  - Both FSMs idle, counters cleared, edge-detect register 0.
- Reset mid-operation aborts any partial RX frame or TX sequence immediately; no further `txStart` is issued.
- Final `rxValid` in cycle N: `dataReceived`=1 in cycle N+1, with `control`/`inputData` already valid in that cycle.
- `clearDR` sampled high in cycle M: `dataReceived`=0 in cycle M+1.
- `transmitData` rising edge sampled in cycle T, with `txBusy`=0: `txStart` in cycle T+1.
- Between bytes, at least one cycle of `txBusy`=0 is observed before the next `txStart`.
- Simultaneous `rxValid` and timeout expiry: the byte wins; it is stored and the counter restarts.
- Simultaneous `clearDR` and `rxValid` in RX_HOLD: the byte is dropped with a `frameError` pulse, and the FSM still moves to RX_RELEASE.
- The timeout counter is $clog2(`FRAME_TIMEOUT`) bits wide and never wraps; it stops at expiry.

## Structure
- Package `sandbox_link_pkg` holds:
  - RX and TX state encodings.
  - `FRAME_BYTES`=5.
  - Byte-index constants for control/status (0) and data MSB (1).
- Sub-module `sandbox_link_tx_serializer` contains the TX FSM, shift register and edge detect. The top level holds the RX FSM, the timeout counter and the `frameError` merge.

## Test plan
- Frame and release:
  - Stimulus: bytes 0x01,0xDE,0xAD,0xBE,0xEF, then `clearDR` high.
  - Response: `dataReceived`=1 one cycle after the last byte, with `control`=0x01 and `inputData`=0xDEADBEEF. `dataReceived` falls one cycle after `clearDR`.
- Timeout:
  - Stimulus: `FRAME_TIMEOUT`=16; send 2 bytes, idle 20 cycles, then send full frame 0x02,0x00,0x00,0x00,0x07.
  - Response: one `frameError` pulse, then `control`=0x02 and `inputData`=0x00000007.
- Overrun:
  - Stimulus: a sixth byte arrives while in RX_HOLD.
  - Response: `frameError` pulses; `inputData` is unchanged.
- Response serialization:
  - Stimulus: `status`=0xA5, `outputData`=0x12345678, `transmitData` raised; a bench transmitter model holds `txBusy` for 10 cycles per byte.
  - Response: bytes A5,12,34,56,78 in order, five `txStart` pulses total.
- Level hold:
  - Stimulus: `transmitData` held high for the whole response and beyond.
  - Response: no second response. After `transmitData` falls and rises again, exactly one new response is sent.
- Reset mid-TX:
  - Stimulus: `reset` asserted during byte 2.
  - Response: all outputs at reset values the next cycle, and no further `txStart`.
